// File: rtl/prco_sched_pkg.sv
// Shared constants for the PRCO instruction sequencer: FSM state codes,
// RAM source codes and small helpers used by the sequencer and its bench.
package prco_sched_pkg;

    // Sequencer states (3-bit, also exported on the debug port).
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_DECWAIT = 3'd3;
    localparam logic [2:0] S_EXEC    = 3'd4;
    localparam logic [2:0] S_MEM     = 3'd5;
    localparam logic [2:0] S_WB      = 3'd6;
    localparam logic [2:0] S_HALT    = 3'd7;

    // Owner of the shared RAM port.
    localparam logic RAM_SRC_FETCH = 1'b0;
    localparam logic RAM_SRC_DATA  = 1'b1;

    // Width of the RAM timeout counter; wide enough for a limit of 255.
    localparam int TMO_CNT_W = 8;

    // True in the states that own an outstanding RAM request.
    function automatic logic is_ram_state(input logic [2:0] state);
        return (state == S_FETCH) || (state == S_MEM);
    endfunction

endpackage

// File: rtl/prco_timeout_ctr.sv
// Up-counter guarding a RAM access. It is held at zero while cleared,
// counts waiting cycles while enabled, and flags the cycle on which one
// more wait would reach LIMIT.
module prco_timeout_ctr
    import prco_sched_pkg::*;
#(
    parameter int LIMIT = 15
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    localparam logic [TMO_CNT_W-1:0] LAST = TMO_CNT_W'(LIMIT - 1);

    logic [TMO_CNT_W-1:0] r_cnt;

    // Count waiting cycles; saturate at the last value so the counter never wraps.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_expired) begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples the pre-edge values, independent of block ordering.
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The cycle holding LAST is the final cycle in which an ack is accepted.
    assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/prco_sched.sv
// PRCO multi-cycle instruction sequencer. Owns the PC and the single RAM
// port, which it shares between instruction fetch and load/store data
// access, and steps each instruction through fetch, decode, execute,
// memory and writeback by pulsing the decoder/ALU/register-file enables.
module prco_sched
    import prco_sched_pkg::*;
#(
    parameter int              PC_W        = 16,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              RAM_TIMEOUT = 15
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_en,
    output logic            q_ram_req,
    output logic            q_ram_src,
    output logic            q_ram_we,
    output logic [PC_W-1:0] q_ram_addr_pc,
    input  logic            i_ram_ack,
    output logic            q_ir_we,
    output logic            q_dec_ce,
    input  logic            i_dec_ce,
    input  logic            i_dec_fetch,
    input  logic            i_req_ram,
    input  logic            i_req_ram_we,
    input  logic            i_reg_we,
    output logic            q_alu_ce,
    output logic            q_reg_we,
    input  logic            i_pc_load,
    input  logic [PC_W-1:0] i_pc_target,
    output logic [PC_W-1:0] q_pc,
    output logic            q_retired,
    output logic            q_err,
    output logic [2:0]      q_state
);

    logic [2:0]      r_state;
    logic [PC_W-1:0] r_pc;

    // Decoder dependency flags captured for the rest of the instruction.
    logic r_req_ram;
    logic r_req_ram_we;
    logic r_reg_we_lat;

    // One-cycle strobes and the sticky fault.
    logic r_ir_we;
    logic r_dec_ce;
    logic r_alu_ce;
    logic r_reg_we;
    logic r_retired;
    logic r_err;

    // Set once the first DECWAIT cycle has passed without a decoder response.
    logic r_dw_late;

    logic w_in_ram;
    logic w_ram_wait;
    logic w_tmo_clr;
    logic w_tmo_expired;

    assign w_in_ram   = is_ram_state(r_state);
    assign w_ram_wait = w_in_ram && !i_ram_ack;

    // The counter is held clear outside the RAM states, so it always starts
    // at zero on entry to FETCH or MEM (no RAM state follows another directly).
    assign w_tmo_clr = !w_in_ram;

    prco_timeout_ctr #(
        .LIMIT (RAM_TIMEOUT)
    ) u_tmo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clr     (w_tmo_clr),
        .i_inc     (w_ram_wait),
        .o_expired (w_tmo_expired)
    );

    // Main sequencer: state, PC, latched decoder flags, strobes and fault.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_req_ram    <= 1'b0;
            r_req_ram_we <= 1'b0;
            r_reg_we_lat <= 1'b0;
            r_ir_we      <= 1'b0;
            r_dec_ce     <= 1'b0;
            r_alu_ce     <= 1'b0;
            r_reg_we     <= 1'b0;
            r_retired    <= 1'b0;
            r_err        <= 1'b0;
            r_dw_late    <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle, so each one set below
            // lasts exactly one cycle without explicit clearing elsewhere.
            r_ir_we   <= 1'b0;
            r_dec_ce  <= 1'b0;
            r_alu_ce  <= 1'b0;
            r_reg_we  <= 1'b0;
            r_retired <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_en) begin
                        r_state <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (i_ram_ack) begin
                        r_ir_we <= 1'b1;
                        r_pc    <= r_pc + 1'b1;
                        r_state <= S_DECODE;
                    end else if (w_tmo_expired) begin
                        r_err   <= 1'b1;
                        r_state <= S_HALT;
                    end
                end

                S_DECODE: begin
                    r_dec_ce  <= 1'b1;
                    r_dw_late <= 1'b0;
                    r_state   <= S_DECWAIT;
                end

                S_DECWAIT: begin
                    // A refetch request beats a valid decode in the same cycle.
                    if (i_dec_fetch) begin
                        r_state <= S_FETCH;
                    end else if (i_dec_ce) begin
                        r_req_ram    <= i_req_ram;
                        r_req_ram_we <= i_req_ram_we;
                        r_reg_we_lat <= i_reg_we;
                        r_state      <= S_EXEC;
                    end else if (r_dw_late) begin
                        r_err   <= 1'b1;
                        r_state <= S_HALT;
                    end else begin
                        r_dw_late <= 1'b1;
                    end
                end

                S_EXEC: begin
                    r_alu_ce <= 1'b1;
                    r_state  <= r_req_ram ? S_MEM : S_WB;
                end

                S_MEM: begin
                    if (i_ram_ack) begin
                        r_state <= S_WB;
                    end else if (w_tmo_expired) begin
                        r_err   <= 1'b1;
                        r_state <= S_HALT;
                    end
                end

                S_WB: begin
                    r_reg_we  <= r_reg_we_lat;
                    r_retired <= 1'b1;
                    // A taken jump replaces the increment applied at fetch.
                    if (i_pc_load) begin
                        r_pc <= i_pc_target;
                    end
                    r_state <= i_en ? S_FETCH : S_IDLE;
                end

                S_HALT: begin
                    r_state <= S_HALT;
                end

                default: begin
                    r_err   <= 1'b1;
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    // RAM port controls decode straight from the state register, so the
    // asynchronous reset drops the request at once.
    assign q_ram_req     = w_in_ram;
    assign q_ram_src     = (r_state == S_MEM) ? RAM_SRC_DATA : RAM_SRC_FETCH;
    assign q_ram_we      = (r_state == S_MEM) && r_req_ram_we;
    assign q_ram_addr_pc = r_pc;

    assign q_ir_we   = r_ir_we;
    assign q_dec_ce  = r_dec_ce;
    assign q_alu_ce  = r_alu_ce;
    assign q_reg_we  = r_reg_we;
    assign q_retired = r_retired;
    assign q_err     = r_err;
    assign q_pc      = r_pc;
    assign q_state   = r_state;

endmodule

// File: tb/tb_prco_sched.sv
// Self-checking bench for prco_sched. The bench plays RAM and decoder,
// keeps its own PC model and per-instruction strobe tallies, and compares
// them with what each instruction class must produce.
module tb_prco_sched;
    import prco_sched_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_en;
    logic        q_ram_req;
    logic        q_ram_src;
    logic        q_ram_we;
    logic [15:0] q_ram_addr_pc;
    logic        i_ram_ack;
    logic        q_ir_we;
    logic        q_dec_ce;
    logic        i_dec_ce;
    logic        i_dec_fetch;
    logic        i_req_ram;
    logic        i_req_ram_we;
    logic        i_reg_we;
    logic        q_alu_ce;
    logic        q_reg_we;
    logic        i_pc_load;
    logic [15:0] i_pc_target;
    logic [15:0] q_pc;
    logic        q_retired;
    logic        q_err;
    logic [2:0]  q_state;

    prco_sched #(
        .PC_W        (16),
        .RESET_PC    (16'h0000),
        .RAM_TIMEOUT (15)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_en          (i_en),
        .q_ram_req     (q_ram_req),
        .q_ram_src     (q_ram_src),
        .q_ram_we      (q_ram_we),
        .q_ram_addr_pc (q_ram_addr_pc),
        .i_ram_ack     (i_ram_ack),
        .q_ir_we       (q_ir_we),
        .q_dec_ce      (q_dec_ce),
        .i_dec_ce      (i_dec_ce),
        .i_dec_fetch   (i_dec_fetch),
        .i_req_ram     (i_req_ram),
        .i_req_ram_we  (i_req_ram_we),
        .i_reg_we      (i_reg_we),
        .q_alu_ce      (q_alu_ce),
        .q_reg_we      (q_reg_we),
        .i_pc_load     (i_pc_load),
        .i_pc_target   (i_pc_target),
        .q_pc          (q_pc),
        .q_retired     (q_retired),
        .q_err         (q_err),
        .q_state       (q_state)
    );

    always #5 i_clk = ~i_clk;

    typedef enum int {K_ALU, K_LOAD, K_STORE, K_NOP, K_JMP} kind_t;
    localparam int W_REQ = 0;
    localparam int W_DEC = 1;
    localparam int W_RET = 2;
    localparam int MAX_WAIT = 14;   // last acceptable ack cycle index with a limit of 15

    int total = 0;
    int bad   = 0;

    // Strobe tallies for the instruction in flight.
    int n_ir, n_dec, n_alu, n_regwe, n_ret, n_data;

    logic [15:0] model_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_tally();
        n_ir = 0; n_dec = 0; n_alu = 0; n_regwe = 0; n_ret = 0; n_data = 0;
    endtask

    // Advance to the next falling edge and tally what the DUT shows there.
    task automatic tick();
        @(negedge i_clk);
        if (q_ir_we)   n_ir++;
        if (q_dec_ce)  n_dec++;
        if (q_alu_ce)  n_alu++;
        if (q_reg_we)  n_regwe++;
        if (q_retired) n_ret++;
        if (q_ram_req && q_ram_src) n_data++;
        if (q_ram_we) chk("we_without_data_src", q_ram_src, 1'b1);
    endtask

    function automatic logic probe(input int which);
        case (which)
            W_REQ:   return q_ram_req;
            W_DEC:   return q_dec_ce;
            W_RET:   return q_retired;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input string tag);
        int n = 0;
        while (!probe(which) && n < 40) begin
            tick();
            n++;
        end
        chk(tag, probe(which), 1'b1);
    endtask

    // Drive one instruction through the DUT and check its externally visible effect.
    task automatic run_instr(input kind_t kind, input int lat_f, input int dly, input int lat_m,
                             input logic [15:0] tgt, input bit drop_en, input bit junk_load);
        bit mem, st, rw;
        mem = (kind == K_LOAD) || (kind == K_STORE);
        st  = (kind == K_STORE);
        rw  = (kind == K_ALU) || (kind == K_LOAD);
        clear_tally();

        wait_for(W_REQ, "fetch_req");
        chk("fetch_src",  q_ram_src, 1'b0);
        chk("fetch_we",   q_ram_we, 1'b0);
        chk("fetch_addr", q_ram_addr_pc, model_pc);
        if (junk_load) begin
            i_pc_load   = 1'b1;
            i_pc_target = 16'($urandom);
        end
        repeat (lat_f) tick();
        i_ram_ack = 1'b1;
        tick();
        i_ram_ack = 1'b0;
        i_pc_load = 1'b0;
        model_pc  = model_pc + 16'd1;
        // A stray ack while decoding must be ignored.
        i_ram_ack = 1'($urandom_range(0, 1));
        tick();
        i_ram_ack = 1'b0;

        wait_for(W_DEC, "dec_ce_seen");
        repeat (dly) tick();
        if (kind == K_NOP) begin
            i_dec_fetch = 1'b1;
            i_dec_ce    = 1'($urandom_range(0, 1));
        end else begin
            i_dec_ce     = 1'b1;
            i_req_ram    = mem;
            i_req_ram_we = mem ? st : 1'($urandom_range(0, 1));
            i_reg_we     = rw;
        end
        if (drop_en) i_en = 1'b0;
        tick();
        i_dec_ce = 1'b0; i_dec_fetch = 1'b0; i_req_ram = 1'b0; i_req_ram_we = 1'b0; i_reg_we = 1'b0;

        if (kind == K_NOP) begin
            chk("nop_state", q_state, S_FETCH);
            chk("nop_ir",    n_ir, 1);
            chk("nop_dec",   n_dec, 1);
            chk("nop_alu",   n_alu, 0);
            chk("nop_regwe", n_regwe, 0);
            chk("nop_ret",   n_ret, 0);
            chk("nop_pc",    q_pc, model_pc);
        end else begin
            if (kind == K_JMP) begin
                i_pc_load   = 1'b1;
                i_pc_target = tgt;
            end
            if (mem) begin
                wait_for(W_REQ, "data_req");
                chk("data_src", q_ram_src, 1'b1);
                chk("data_we",  q_ram_we, st);
                repeat (lat_m) tick();
                i_ram_ack = 1'b1;
                tick();
                i_ram_ack = 1'b0;
            end
            wait_for(W_RET, "retire");
            i_pc_load = 1'b0;
            if (kind == K_JMP) model_pc = tgt;
            chk("ir_pulses",    n_ir, 1);
            chk("dec_pulses",   n_dec, 1);
            chk("alu_pulses",   n_alu, 1);
            chk("regwe_pulses", n_regwe, rw);
            chk("ret_pulses",   n_ret, 1);
            chk("data_access",  (n_data > 0), mem);
            chk("pc_after",     q_pc, model_pc);
            if (drop_en) begin
                chk("park_state", q_state, S_IDLE);
                repeat (3) tick();
                chk("park_hold", q_state, S_IDLE);
                chk("park_req",  q_ram_req, 1'b0);
                chk("park_ret",  n_ret, 1);
                i_en = 1'b1;
            end
        end
    endtask

    initial begin
        kind_t k;
        i_reset = 1'b0; i_en = 1'b0; i_ram_ack = 1'b0; i_dec_ce = 1'b0; i_dec_fetch = 1'b0;
        i_req_ram = 1'b0; i_req_ram_we = 1'b0; i_reg_we = 1'b0; i_pc_load = 1'b0; i_pc_target = '0;
        clear_tally();

        // Reset, then idle with run disabled.
        repeat (2) @(negedge i_clk);
        i_reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_pc",      q_pc, 16'h0000);
            chk("idle_state",   q_state, S_IDLE);
            chk("idle_strobes", {q_ir_we, q_dec_ce, q_alu_ce, q_reg_we, q_retired, q_ram_req, q_err}, 0);
        end
        model_pc = 16'h0000;
        i_en = 1'b1;

        // Directed flows: ADD, SW, JMP 0x0005, NOP, JMP 0x0040, JMP 0xFFFF with wrap.
        run_instr(K_ALU,   1, 1, 0, 16'h0000, 1'b0, 1'b0);
        chk("add_pc", q_pc, 16'h0001);
        run_instr(K_STORE, 1, 1, 1, 16'h0000, 1'b0, 1'b0);
        run_instr(K_JMP,   0, 1, 0, 16'h0005, 1'b0, 1'b0);
        run_instr(K_NOP,   1, 1, 0, 16'h0000, 1'b0, 1'b0);
        chk("nop_pc_6", q_pc, 16'h0006);
        run_instr(K_JMP,   2, 0, 0, 16'h0040, 1'b0, 1'b1);
        run_instr(K_ALU,   0, 1, 0, 16'h0000, 1'b0, 1'b0);
        run_instr(K_JMP,   0, 1, 0, 16'hFFFF, 1'b0, 1'b0);
        run_instr(K_ALU,   3, 1, 0, 16'h0000, 1'b0, 1'b0);
        chk("wrap_pc", q_pc, 16'h0000);
        // Acks on the last acceptable cycle still succeed.
        run_instr(K_LOAD, MAX_WAIT, 1, MAX_WAIT, 16'h0000, 1'b1, 1'b0);
        chk("edge_ack_no_err", q_err, 1'b0);

        // Randomized instruction mix.
        for (int i = 0; i < 40; i++) begin
            k = kind_t'($urandom_range(0, 4));
            run_instr(k, $urandom_range(0, MAX_WAIT), $urandom_range(0, 1), $urandom_range(0, MAX_WAIT),
                      16'($urandom), (k != K_NOP) && ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
        end
        chk("random_no_err", q_err, 1'b0);

        // Decoder silent for two cycles: fault and halt.
        clear_tally();
        wait_for(W_REQ, "dto_req");
        i_ram_ack = 1'b1;
        tick();
        i_ram_ack = 1'b0;
        wait_for(W_DEC, "dto_dec");
        tick();
        tick();
        chk("dto_err",   q_err, 1'b1);
        chk("dto_state", q_state, S_HALT);
        i_ram_ack = 1'b1;
        repeat (3) tick();
        i_ram_ack = 1'b0;
        chk("dto_stays_halted", q_state, S_HALT);
        chk("dto_no_req",       q_ram_req, 1'b0);

        // Reset clears the sticky fault.
        i_reset = 1'b0;
        #1;
        chk("rst_err",   q_err, 1'b0);
        chk("rst_state", q_state, S_IDLE);
        chk("rst_pc",    q_pc, 16'h0000);
        @(negedge i_clk);
        i_reset = 1'b1;
        model_pc = 16'h0000;

        // RAM never acks during fetch: fault after the fifteenth waiting cycle.
        wait_for(W_REQ, "rto_req");
        repeat (MAX_WAIT) tick();
        chk("rto_still_waiting", q_ram_req, 1'b1);
        chk("rto_no_err_yet",    q_err, 1'b0);
        tick();
        chk("rto_err",   q_err, 1'b1);
        chk("rto_state", q_state, S_HALT);
        chk("rto_req",   q_ram_req, 1'b0);
        i_reset = 1'b0;
        #1;
        chk("rto_err_cleared", q_err, 1'b0);
        @(negedge i_clk);
        i_reset = 1'b1;

        // Reset asserted in the middle of a fetch drops the request at once.
        wait_for(W_REQ, "mid_req");
        #2;
        i_reset = 1'b0;
        #1;
        chk("mid_reset_req", q_ram_req, 1'b0);
        @(negedge i_clk);
        i_reset = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
